// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the multi-channel SRAM arbiter.
// Strobe levels are named so the active-low pin polarity lives in one place.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_FINISH = 2'd3
  } arb_state_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_ch_picker.sv
// Combinational winner select: lowest index in fixed mode, or the first
// requester after the last grant (wrapping) in round-robin mode.
module ch_picker #(
  parameter int NUM_CH  = 3,
  parameter int RR_MODE = 0
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic                      valid,
  output logic [$clog2(NUM_CH)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_CH);

  int               start;
  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    start = (RR_MODE != 0) ? (int'(last_grant) + 1) % NUM_CH : 0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = IDX_W'((start + off) % NUM_CH);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// N-channel arbiter in front of one asynchronous SRAM: grant, SETUP, timed
// ACCESS, FINISH with a done pulse. Every pin and status output is registered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int RR_MODE     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          we,
  input  logic [NUM_CH*ADDR_W-1:0]   addr,
  input  logic [NUM_CH*DATA_W-1:0]   wdata,
  output logic [NUM_CH-1:0]          done,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic [ADDR_W-1:0]          sram_addr,
  inout  wire  [DATA_W-1:0]          sram_data,
  output logic                       sram_en,
  output logic                       sram_oe,
  output logic                       sram_we
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  arb_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [IDX_W-1:0]  grant_reg, grant_next;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic              recover_reg, recover_next;
  logic              en_reg, en_next, oe_reg, oe_next, wen_reg, wen_next;
  logic              drive_reg, drive_next, busy_reg, busy_next;
  logic [NUM_CH-1:0] done_reg, done_next;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] ch_addr  [NUM_CH];
  logic [DATA_W-1:0] ch_wdata [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign ch_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  ch_picker #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_picker (
    .req        (req),
    .last_grant (rr_ptr_reg),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    grant_next   = grant_reg;
    rr_ptr_next  = rr_ptr_reg;
    recover_next = (state_reg == ST_FINISH);
    case (state_reg)
      ST_IDLE: begin
        // The cycle right after done is a bus-quiet gap; a req still high
        // there is picked up as a fresh request one cycle later.
        if (pick_valid && !recover_reg) begin
          state_next  = ST_SETUP;
          we_next     = we[pick_idx];
          addr_next   = ch_addr[pick_idx];
          wdata_next  = ch_wdata[pick_idx];
          grant_next  = pick_idx;
          rr_ptr_next = pick_idx;
        end
      end
      ST_SETUP: begin
        cnt_next   = CNT_W'(WAIT_CYCLES - 1);
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_reg == '0) begin
          state_next = ST_FINISH;
          if (!we_reg) rdata_next = sram_data;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    // Pin levels are decoded from the upcoming state so they leave flops.
    en_next    = (state_next == ST_IDLE) ? STROBE_OFF : STROBE_ON;
    oe_next    = (!we_next && (state_next == ST_SETUP || state_next == ST_ACCESS))
                 ? STROBE_ON : STROBE_OFF;
    wen_next   = (we_next && state_next == ST_ACCESS) ? STROBE_ON : STROBE_OFF;
    drive_next = we_next && (state_next != ST_IDLE);
    busy_next  = (state_next != ST_IDLE);
    done_next  = '0;
    if (state_next == ST_FINISH) done_next[grant_next] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      grant_reg   <= '0;
      rr_ptr_reg  <= IDX_W'(NUM_CH - 1);
      recover_reg <= 1'b0;
      en_reg      <= STROBE_OFF;
      oe_reg      <= STROBE_OFF;
      wen_reg     <= STROBE_OFF;
      drive_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      grant_reg   <= grant_next;
      rr_ptr_reg  <= rr_ptr_next;
      recover_reg <= recover_next;
      en_reg      <= en_next;
      oe_reg      <= oe_next;
      wen_reg     <= wen_next;
      drive_reg   <= drive_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign done      = done_reg;
  assign rdata     = rdata_reg;
  assign busy      = busy_reg;
  assign grant_id  = grant_reg;
  assign sram_addr = addr_reg;
  assign sram_en   = en_reg;
  assign sram_oe   = oe_reg;
  assign sram_we   = wen_reg;
  assign sram_data = drive_reg ? wdata_reg : 'z;

endmodule
